pattern_sequencer: RTL and testbench

- Parametrised multi-bank pattern sequencer, successor to the single-clock 16-bit sequencer driving the bean configuration bus.
- Host loads patterns byte-wise into NBANKS banks; on start the engine plays the selected bank word-per-clock onto seq_out.
- Play modes: single pass, N repeats, or continuous loop, with abort.
- Strobes are synchronous to clk; no second clock domain.

---
 rtl/pattern_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_pattern_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// Multi-bank pattern sequencer: the host loads words byte-wise into banks, then
// the engine plays a selected bank word-per-clock with single, repeat or loop modes.
module pattern_sequencer #(
  parameter int unsigned           OUT_W     = 16,
  parameter int unsigned           DEPTH     = 32,
  parameter int unsigned           NBANKS    = 4,
  parameter logic [OUT_W-1:0]      IDLE_WORD = 16'h1404
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en_i,
  input  logic                      wr_stb_i,
  input  logic [$clog2(NBANKS)-1:0] wr_bank_i,
  input  logic [7:0]                wr_data_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic [$clog2(NBANKS)-1:0] bank_sel_i,
  input  logic                      loop_en_i,
  input  logic [7:0]                rep_count_i,
  output logic [OUT_W-1:0]          seq_out_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      load_full_o
);

  localparam int unsigned BYTES = OUT_W / 8;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned BW    = $clog2(NBANKS);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  logic [OUT_W-1:0] mem [NBANKS*DEPTH];
  logic [PW-1:0]    len_q [NBANKS];

  // Load path
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    byte_cnt_q;
  logic             load_full_q;
  logic [OUT_W-1:0] asm_q;
  logic [BW-1:0]    wbank_q;
  logic             byte_acc, first_byte, word_done;
  logic [BW-1:0]    wbank;
  logic [OUT_W-1:0] asm_d;

  // Play path
  state_t           state_q, state_d;
  logic [PW-1:0]    idx_q, idx_d, plen_q, plen_d;
  logic [7:0]       reps_q, reps_d;
  logic             loop_q, loop_d;
  logic [BW-1:0]    bank_q, bank_d;
  logic [OUT_W-1:0] seq_q, seq_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [BW+AW-1:0] rd_addr;
  logic [OUT_W-1:0] rd_word;

  assign byte_acc   = wr_en_i && wr_stb_i && !busy_q && !load_full_q;
  assign first_byte = (wr_ptr_q == '0) && (byte_cnt_q == '0);
  assign wbank      = first_byte ? wr_bank_i : wbank_q;
  assign word_done  = byte_acc && (byte_cnt_q == CW'(BYTES - 1));
  assign asm_d      = OUT_W'(asm_q << 8) | OUT_W'(wr_data_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      load_full_q <= 1'b0;
      asm_q       <= '0;
      wbank_q     <= '0;
    end else if (!wr_en_i) begin
      wr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      load_full_q <= 1'b0;
    end else if (byte_acc) begin
      asm_q <= asm_d;
      if (first_byte) wbank_q <= wr_bank_i;
      if (word_done) begin
        byte_cnt_q  <= '0;
        wr_ptr_q    <= wr_ptr_q + PW'(1);
        load_full_q <= (wr_ptr_q + PW'(1)) == PW'(DEPTH);
      end else begin
        byte_cnt_q <= byte_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBANKS; b++) len_q[b] <= '0;
    end else if (word_done) begin
      len_q[wbank] <= wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (word_done) mem[{wbank, wr_ptr_q[AW-1:0]}] <= asm_d;
  end

  // Address of the word that will be registered onto seq_out at the next edge
  always_comb begin
    rd_addr = {bank_q, idx_q[AW-1:0]};
    if (state_q == IDLE)       rd_addr = {bank_sel_i, AW'(0)};
    else if (idx_q == plen_q)  rd_addr = {bank_q, AW'(0)};
  end

  assign rd_word = mem[rd_addr];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    plen_d  = plen_q;
    reps_d  = reps_q;
    loop_d  = loop_q;
    bank_d  = bank_q;
    seq_d   = seq_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i && !wr_en_i) begin
          bank_d = bank_sel_i;
          loop_d = loop_en_i;
          reps_d = rep_count_i;
          plen_d = len_q[bank_sel_i];
          if (len_q[bank_sel_i] == '0) begin
            done_d = 1'b1;
          end else begin
            seq_d   = rd_word;
            idx_d   = PW'(1);
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (stop_i) begin
          seq_d   = IDLE_WORD;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (idx_q == plen_q) begin
          if (loop_q || reps_q != 8'd0) begin
            seq_d = rd_word;
            idx_d = PW'(1);
            if (!loop_q) reps_d = reps_q - 8'd1;
          end else begin
            seq_d   = IDLE_WORD;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          seq_d = rd_word;
          idx_d = idx_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      plen_q  <= '0;
      reps_q  <= '0;
      loop_q  <= 1'b0;
      bank_q  <= '0;
      seq_q   <= IDLE_WORD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      plen_q  <= plen_d;
      reps_q  <= reps_d;
      loop_q  <= loop_d;
      bank_q  <= bank_d;
      seq_q   <= seq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign seq_out_o   = seq_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign load_full_o = load_full_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: loads banks, plays them in each mode and
// compares outputs against hand-computed values with immediate assertions.
module tb_pattern_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_stb, start, stop, loop_en;
  logic [1:0]  wr_bank, bank_sel;
  logic [7:0]  wr_data, rep_count;
  logic [15:0] seq_out;
  logic        busy, done, load_full;
  int          checks = 0;
  int          errors = 0;

  pattern_sequencer dut (
    .clk(clk), .rst(rst),
    .wr_en_i(wr_en), .wr_stb_i(wr_stb), .wr_bank_i(wr_bank), .wr_data_i(wr_data),
    .start_i(start), .stop_i(stop), .bank_sel_i(bank_sel), .loop_en_i(loop_en),
    .rep_count_i(rep_count),
    .seq_out_o(seq_out), .busy_o(busy), .done_o(done), .load_full_o(load_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr_stb  = 1'b1;
    wr_data = b;
    tick();
    wr_stb  = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] w);
    wr_byte(w[15:8]);
    wr_byte(w[7:0]);
  endtask

  task automatic start_play(input logic [1:0] b, input logic lp, input logic [7:0] r);
    bank_sel  = b;
    loop_en   = lp;
    rep_count = r;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_en = 0; wr_stb = 0; start = 0; stop = 0; loop_en = 0;
    wr_bank = 0; bank_sel = 0; wr_data = 0; rep_count = 0;
    repeat (2) tick();
    chk("reset_seq", seq_out, 16'h1404);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_full", 16'(load_full), 16'd0);
    rst = 1'b0;
    tick();

    // Bank1 <- 0001..0004
    wr_en = 1'b1; wr_bank = 2'd1;
    for (int w = 1; w <= 4; w++) load_word(16'(w));
    wr_en = 1'b0;
    tick();

    $display("single pass bank1");
    start_play(2'd1, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("single_word", seq_out, 16'(i + 1));
      chk("single_busy", 16'(busy), 16'd1);
      chk("single_nodone", 16'(done), 16'd0);
    end
    tick();
    chk("single_end_seq", seq_out, 16'h1404);
    chk("single_end_busy", 16'(busy), 16'd0);
    chk("single_end_done", 16'(done), 16'd1);
    tick();
    chk("single_done_clr", 16'(done), 16'd0);

    $display("repeat x3 bank1");
    start_play(2'd1, 1'b0, 8'd2);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      chk("rep_word", seq_out, 16'((i % 4) + 1));
      chk("rep_nodone", 16'(done), 16'd0);
    end
    tick();
    chk("rep_end_seq", seq_out, 16'h1404);
    chk("rep_end_done", 16'(done), 16'd1);
    chk("rep_end_busy", 16'(busy), 16'd0);

    $display("loop bank1 with stop");
    tick();
    start_play(2'd1, 1'b1, 8'd0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      chk("loop_word", seq_out, 16'((i % 4) + 1));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0; loop_en = 1'b0;
    chk("stop_seq", seq_out, 16'h1404);
    chk("stop_busy", 16'(busy), 16'd0);
    chk("stop_nodone", 16'(done), 16'd0);
    tick();
    chk("stop_nodone2", 16'(done), 16'd0);

    $display("load 33 words into bank0");
    wr_en = 1'b1; wr_bank = 2'd0;
    for (int w = 0; w < 33; w++) begin
      load_word(16'hA000 + 16'(w));
      if (w == 30) chk("not_full_31", 16'(load_full), 16'd0);
      if (w == 31) chk("full_32", 16'(load_full), 16'd1);
    end
    chk("full_33", 16'(load_full), 16'd1);
    wr_en = 1'b0;
    tick();
    chk("full_clr", 16'(load_full), 16'd0);
    start_play(2'd0, 1'b0, 8'd0);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick();
      chk("b0_word", seq_out, 16'hA000 + 16'(i));
    end
    tick();
    chk("b0_end_seq", seq_out, 16'h1404);
    chk("b0_end_done", 16'(done), 16'd1);

    $display("start while loading ignored");
    wr_en = 1'b1;
    start_play(2'd1, 1'b0, 8'd0);
    chk("wr_start_busy", 16'(busy), 16'd0);
    chk("wr_start_done", 16'(done), 16'd0);
    wr_en = 1'b0;
    tick();

    $display("empty bank3");
    start_play(2'd3, 1'b0, 8'd0);
    chk("empty_done", 16'(done), 16'd1);
    chk("empty_busy", 16'(busy), 16'd0);
    chk("empty_seq", seq_out, 16'h1404);
    tick();
    chk("empty_done_clr", 16'(done), 16'd0);

    $display("partial word discarded, bank2");
    wr_en = 1'b1; wr_bank = 2'd2;
    wr_byte(8'hBE);
    wr_en = 1'b0;
    tick();
    wr_en = 1'b1;
    load_word(16'h1234);
    wr_en = 1'b0;
    tick();
    start_play(2'd2, 1'b0, 8'd0);
    chk("partial_word", seq_out, 16'h1234);
    tick();
    chk("partial_done", 16'(done), 16'd1);

    $display("reset mid-play");
    start_play(2'd1, 1'b0, 8'd0);
    tick();
    chk("pre_rst_word", seq_out, 16'h0002);
    #2 rst = 1'b1;
    #1;
    chk("rst_play_seq", seq_out, 16'h1404);
    chk("rst_play_busy", 16'(busy), 16'd0);
    @(posedge clk); #1 rst = 1'b0;

    $display("reset mid-load");
    wr_en = 1'b1; wr_bank = 2'd1;
    wr_byte(8'h00);
    #2 rst = 1'b1;
    #1;
    chk("rst_load_full", 16'(load_full), 16'd0);
    chk("rst_load_seq", seq_out, 16'h1404);
    @(posedge clk); #1 rst = 1'b0;
    wr_en = 1'b0;
    tick();
    start_play(2'd1, 1'b0, 8'd0);
    chk("post_rst_done", 16'(done), 16'd1);
    chk("post_rst_busy", 16'(busy), 16'd0);
    chk("post_rst_seq", seq_out, 16'h1404);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
